// File: rtl/serial_parity_checker_if.sv
// ---------------------------------------------------------------------------
// serial_parity_checker_if
// Bundles the two streams around the serial parity checker:
//   serial input stream : s_valid, s_bit, s_sof  -> checker,  s_ready <- checker
//   word output stream  : m_valid, m_data, m_par_err <- checker, m_ready -> checker
// Modports:
//   master : environment side (drives the serial bits and the consumer ready)
//   slave  : checker side (accepts serial bits, presents checked words)
// ---------------------------------------------------------------------------
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_bit;
    logic              s_sof;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_par_err;

    modport master (
        output s_valid, s_bit, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_par_err
    );

    modport slave (
        input  s_valid, s_bit, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_par_err
    );
endinterface

// File: rtl/serial_parity_checker.sv
// ---------------------------------------------------------------------------
// serial_parity_checker
// Receives a serial stream of DATA_W data bits (LSB first, first bit flagged
// by s_sof) followed by one odd-parity bit, and presents each completed word
// with a parity-error flag on a valid/ready output. Keeps a wrapping frame
// counter and a saturating parity-error counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : slave side of serial_parity_checker_if (serial in, word out)
//   sync_err   : one-cycle pulse when a frame is aborted by an early s_sof
//   frame_cnt  : completed frames, wraps
//   err_cnt    : frames with parity error, saturates at all-ones
// ---------------------------------------------------------------------------
module serial_parity_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_parity_checker_if.slave bus,
    output logic                 sync_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q, par_d;
    logic               m_valid_q, m_valid_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic               m_par_err_q, m_par_err_d;
    logic               sync_err_q, sync_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic s_ready;
    logic xfer;
    logic last_bit;
    logic load;
    logic par_err_now;

    // The parity bit is held off only while the output slot is still full;
    // data bits keep flowing so the next frame can assemble behind it.
    assign s_ready  = !((state_q == PARITY) && m_valid_q && !bus.m_ready);
    assign xfer     = bus.s_valid && s_ready;
    assign last_bit = (idx_q == IDX_W'(DATA_W - 1));
    // An s_sof on the parity cycle is an abort, never a parity bit.
    assign load     = xfer && (state_q == PARITY) && !bus.s_sof;
    // par_q already holds the XOR of all data bits.
    assign par_err_now = !(par_q ^ bus.s_bit);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_par_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_par_err_q <= m_par_err_d;
            sync_err_q  <= sync_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            case (state_q)
                IDLE:    if (bus.s_sof) state_d = DATA;
                DATA:    if (bus.s_sof) state_d = DATA;
                         else if (last_bit) state_d = PARITY;
                PARITY:  state_d = bus.s_sof ? DATA : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / output logic
    always_comb begin
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        m_data_d    = m_data_q;
        m_par_err_d = m_par_err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        sync_err_d  = 1'b0;
        // A consumed word frees the slot; a load at the same edge wins below.
        m_valid_d   = m_valid_q && !bus.m_ready;

        if (xfer) begin
            if (bus.s_sof) begin
                // Start (or restart) a frame: this bit is data bit 0.
                shift_d    = '0;
                shift_d[0] = bus.s_bit;
                par_d      = bus.s_bit;
                idx_d      = IDX_W'(1);
                sync_err_d = (state_q != IDLE);
            end else if (state_q == DATA) begin
                shift_d[idx_q] = bus.s_bit;
                par_d          = par_q ^ bus.s_bit;
                idx_d          = idx_q + IDX_W'(1);
            end
        end

        if (load) begin
            m_valid_d   = 1'b1;
            m_data_d    = shift_q;
            m_par_err_d = par_err_now;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (par_err_now && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_par_err = m_par_err_q;
    assign sync_err      = sync_err_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// ---------------------------------------------------------------------------
// tb_serial_parity_checker
// Directed frames followed by randomized traffic (random gaps, discarded
// idle bits, early-s_sof aborts, random consumer back-pressure). Expected
// words are pushed into a queue when a frame is sent; an independent monitor
// pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_serial_parity_checker;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    serial_parity_checker_if #(.DATA_W(DATA_W)) bus ();

    serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sync_err  (sync_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        logic [CNT_W-1:0]  fc;
        logic [CNT_W-1:0]  ec;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   model_frames = 0;
    int   model_errs = 0;
    int   exp_sync = 0;
    int   seen_sync = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    // Reference model: odd parity means the parity bit is 1 exactly when the
    // data has an even number of ones.
    task automatic push_exp(input logic [DATA_W-1:0] d, input logic p);
        exp_t e;
        logic correct;
        correct = ($countones(d) % 2) == 0;
        model_frames = model_frames + 1;
        e.data = d;
        e.perr = (p != correct);
        if (e.perr && model_errs < (1 << CNT_W) - 1) model_errs = model_errs + 1;
        e.fc = CNT_W'(model_frames % (1 << CNT_W));
        e.ec = CNT_W'(model_errs);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_frames = 0;
        model_errs   = 0;
    endtask

    // Consumer ready driver
    initial begin
        forever begin
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
            @(posedge clk);
            #1;
        end
    end

    // Sends one bit; waits (bounded) for s_ready. Entered just after a posedge.
    task automatic send_bit(input logic b, input logic sof);
        int n;
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_bit   = b;
        bus.s_sof   = sof;
        n = 0;
        @(negedge clk);
        while (!bus.s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: s_ready=%b required 1 within 300 cycles", bus.s_ready);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_bit   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p);
        push_exp(d, p);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i], i == 0);
        send_bit(p, 1'b0);
    endtask

    // n bits of a frame that will be cut short
    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), i == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            n++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
        end
        // let the last handshake settle
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_par_err !== 1'b0 ||
            sync_err !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0 || bus.s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: m_valid=%b m_data=%h m_par_err=%b sync_err=%b frame_cnt=%0d err_cnt=%0d s_ready=%b, required 0 0 0 0 0 0 s_ready=1",
                     bus.m_valid, bus.m_data, bus.m_par_err, sync_err, frame_cnt, err_cnt, bus.s_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops on every output handshake, checks hold stability and
    // counts sync_err pulses.
    initial begin
        logic              hold;
        logic [DATA_W-1:0] hold_data;
        logic              hold_perr;
        exp_t              e;
        hold = 1'b0;
        hold_data = '0;
        hold_perr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    tests++;
                    if (bus.m_valid !== 1'b1 || bus.m_data !== hold_data || bus.m_par_err !== hold_perr) begin
                        fails++;
                        $display("FAIL hold_stable: m_valid=%b m_data=%h m_par_err=%b, required 1 %h %b",
                                 bus.m_valid, bus.m_data, bus.m_par_err, hold_data, hold_perr);
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL word_unexpected: m_data=%h m_par_err=%b, required no word", bus.m_data, bus.m_par_err);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.m_data !== e.data || bus.m_par_err !== e.perr ||
                            frame_cnt !== e.fc || err_cnt !== e.ec) begin
                            fails++;
                            $display("FAIL word: data=%h perr=%b frame_cnt=%0d err_cnt=%0d, required %h %b %0d %0d",
                                     bus.m_data, bus.m_par_err, frame_cnt, err_cnt, e.data, e.perr, e.fc, e.ec);
                        end else begin
                            $display("[TB] word data=%h perr=%b frame_cnt=%0d err_cnt=%0d ok",
                                     bus.m_data, bus.m_par_err, frame_cnt, err_cnt);
                        end
                    end
                end
                if (sync_err) seen_sync++;
                hold      = bus.m_valid && !bus.m_ready;
                hold_data = bus.m_data;
                hold_perr = bus.m_par_err;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic              p;
        int                n;
        bus.s_valid = 1'b0;
        bus.s_bit   = 1'b0;
        bus.s_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Good frame
        send_frame(8'hA5, 1'b1);
        // Bad parity then good parity
        send_frame(8'hA5, 1'b0);
        send_frame(8'hFF, 1'b1);
        drain();

        // Back-pressure: second parity bit must wait for the consumer
        rdy_mode = 2;
        send_frame(8'h00, 1'b1);
        push_exp(8'h3C, 1'b1);
        for (int i = 0; i < DATA_W; i++) send_bit(d_bit(8'h3C, i), i == 0);
        bus.s_valid = 1'b1;
        bus.s_bit   = 1'b1;
        bus.s_sof   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (bus.s_ready !== 1'b0 || bus.m_data !== 8'h00 || bus.m_valid !== 1'b1) begin
                fails++;
                $display("FAIL backpressure: s_ready=%b m_valid=%b m_data=%h, required 0 1 00",
                         bus.s_ready, bus.m_valid, bus.m_data);
            end
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_bit(1'b1, 1'b0);
        drain();

        // Early s_sof abort on bit 4
        send_partial(4);
        exp_sync++;
        send_frame(8'h81, 1'b0);
        drain();

        // Reset mid-frame
        send_partial(5);
        do_reset();
        send_frame(8'h01, 1'b0);
        drain();

        // Counter saturation / wrap with CNT_W=4
        do_reset();
        for (int k = 0; k < 17; k++) begin
            d = DATA_W'($urandom);
            p = ($countones(d) % 2) != 0;   // deliberately wrong parity
            send_frame(d, p);
        end
        drain();
        tests++;
        if (frame_cnt !== 4'd1 || err_cnt !== 4'd15) begin
            fails++;
            $display("FAIL counters_sat: frame_cnt=%0d err_cnt=%0d, required 1 15", frame_cnt, err_cnt);
        end

        // Randomized traffic
        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                send_partial($urandom_range(1, DATA_W));
                exp_sync++;
            end
            send_frame(DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        tests++;
        if (seen_sync != exp_sync) begin
            fails++;
            $display("FAIL sync_err_count: pulses=%0d, required %0d", seen_sync, exp_sync);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic d_bit(input logic [DATA_W-1:0] v, input int i);
        return v[i];
    endfunction
endmodule
